timer_irq_source: RTL and testbench
===================================

Name: timer_irq_source

Overview:
- Memory-mapped countdown timer. It is the interrupt initiator that drives one bit of the CP0 HWInt[5:0] bus.
- The CPU bridge writes and reads three word registers: CTRL, PRESET and COUNT.
- When COUNT expires, the block raises irq. CP0 samples irq into Cause.IP and may take the interrupt.
- Two modes: one-shot (irq held until software acknowledges) and auto-reload (one-cycle irq pulse per period).

Parameters:
- CNT_W, 32, width of the PRESET and COUNT registers. rdata is zero-extended to 32 bits.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- addr  in  2  word offset: 0 = CTRL, 1 = PRESET, 2 = COUNT, 3 = reserved
- we  in  1  write strobe, sampled on posedge clk
- wdata  in  32  write data
- rdata  out  32  combinational read of the register selected by addr
- irq  out  1  interrupt request to CP0 HWInt; irq = irq_flag & CTRL.IM

Behaviour:
- Register map:
  - CTRL[0] Enable, CTRL[2:1] Mode (00 one-shot, 01 auto-reload, 1x treated as 00), CTRL[3] IM. Other CTRL bits read 0.
  - PRESET is read/write. COUNT is read-only; writes to it are ignored.
  - Offset 3 reads 0, and writes to it are ignored.
- Reset: CTRL = 0, PRESET = 0, COUNT = 0, irq_flag = 0, state = IDLE. Therefore irq = 0 and rdata is 0 at every offset.
- FSM states: IDLE, LOAD, CNT, INT. All transitions happen on posedge clk.
  - IDLE: if Enable = 1, go to LOAD; otherwise stay.
  - LOAD: COUNT <= PRESET, go to CNT.
  - CNT, checked in this order:
    - Enable = 0: go to IDLE; COUNT holds.
    - COUNT > 1: COUNT <= COUNT - 1.
    - COUNT == 1: COUNT <= 0, irq_flag <= 1, go to INT.
    - COUNT == 0 (PRESET was 0): irq_flag <= 1, go to INT.
  - INT, Mode 00: Enable <= 0, go to IDLE. irq_flag stays 1.
  - INT, Mode 01: irq_flag <= 0, go to LOAD. irq is high for exactly the one cycle spent in INT.
- Acknowledge: any write to CTRL clears irq_flag on the same edge. This applies even if the written value equals the old value.
- Latency: write Enable = 1 at edge E with PRESET = N ≥ 1.
  - LOAD after E+1, COUNT = N after E+2.
  - COUNT = N-k after edge E+2+k.
  - irq rises after edge E+2+N, provided IM = 1.
  - Auto-reload period is N+2 cycles, edge to edge.
- Simultaneous events:
  - A software CTRL write wins over the FSM's Enable clear in INT.
  - If a CTRL write coincides with irq_flag being set (COUNT==1 edge), the set wins. A new expiry must not be lost.
- Writes during counting:
  - A PRESET write takes effect only at the next LOAD.
  - A CTRL write with Enable = 0 stops the count on the next edge; COUNT keeps its value.
  - Re-enabling goes IDLE → LOAD and reloads from PRESET. There is no resume.
- IM only gates the output. irq_flag still sets while IM = 0, so setting IM later exposes a pending flag.
- Arithmetic: unsigned, CNT_W bits. COUNT never wraps below 0.
- irq is a registered-flag AND a register bit: glitch-free and synchronous to clk.
- reset asserted in any state returns all registers to reset values on that edge.

Decomposition:
- Shared package:
  - state encoding: IDLE = 2'd0, LOAD = 2'd1, CNT = 2'd2, INT = 2'd3;
  - register offsets;
  - CTRL bit positions;
  - mode codes.
- Single module. A separate register-file sub-module is not warranted.

Test Plan:
- After reset: read offsets 0, 1, 2, 3 gives 0, 0, 0, 0; irq = 0.
- One-shot expiry:
  - Stimulus: PRESET = 5, then CTRL = 0x9 (Enable, IM, mode 00).
  - Response: COUNT reads 5, 4, 3, 2, 1, 0 on successive cycles; irq rises 7 edges after the CTRL write; CTRL reads 0x8 afterwards; irq stays high.
  - Acknowledge: write CTRL = 0x8 drops irq next edge.
- Auto-reload: PRESET = 3, CTRL = 0xB. irq is a one-cycle pulse every 5 cycles for at least 3 periods.
- PRESET = 0, CTRL = 0x9: irq rises 3 edges after the write.
- Mid-count stop: PRESET = 10, enable, then after 4 count cycles write CTRL = 0x8.
  - COUNT freezes at 6; irq = 0.
  - Re-enable with CTRL = 0x9: COUNT reloads to 10.
- IM masking:
  - CTRL = 0x1, PRESET = 2: expiry occurs with irq = 0; the flag is set internally.
  - Writing CTRL = 0x8 clears the flag, so irq stays 0.
  - Repeat with mode 01 and IM set later: irq pulses appear only after IM = 1.

Source files
------------

// File: rtl/timer_irq_source_pkg.sv
// ---------------------------------------------------------------------------
// timer_irq_source_pkg
//   Shared definitions for the memory-mapped countdown timer:
//   FSM state encoding, register word offsets, CTRL bit positions and
//   mode codes.
// ---------------------------------------------------------------------------
package timer_irq_source_pkg;

   // FSM state encoding.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_CNT  = 2'd2,
      ST_INT  = 2'd3
   } state_t;

   // Register word offsets as seen on addr.
   localparam logic [1:0] OFF_CTRL   = 2'd0;
   localparam logic [1:0] OFF_PRESET = 2'd1;
   localparam logic [1:0] OFF_COUNT  = 2'd2;
   localparam logic [1:0] OFF_RSVD   = 2'd3;

   // CTRL bit positions.
   localparam int CTRL_EN_BIT  = 0;
   localparam int CTRL_MODE_LO = 1;
   localparam int CTRL_MODE_HI = 2;
   localparam int CTRL_IM_BIT  = 3;

   // Mode codes. Codes 2'b1x behave as one-shot.
   localparam logic [1:0] MODE_ONESHOT = 2'b00;
   localparam logic [1:0] MODE_RELOAD  = 2'b01;

   // Only the auto-reload code selects reload behaviour; everything else is one-shot.
   function automatic logic is_reload(input logic [1:0] mode);
      return (mode == MODE_RELOAD);
   endfunction

endpackage

// File: rtl/timer_irq_source.sv
// ---------------------------------------------------------------------------
// timer_irq_source
//   Memory-mapped countdown timer driving one CP0 HWInt line.
//   Registers: CTRL (Enable, Mode, IM), PRESET (r/w), COUNT (read-only).
//   One-shot mode holds irq until software writes CTRL; auto-reload mode
//   produces a one-cycle irq pulse every PRESET+2 cycles.
//
// Ports
//   clk    in   1   clock
//   reset  in   1   synchronous, active-high reset
//   addr   in   2   word offset: 0 CTRL, 1 PRESET, 2 COUNT, 3 reserved
//   we     in   1   write strobe, sampled on posedge clk
//   wdata  in  32   write data
//   rdata  out 32   combinational read of the register selected by addr
//   irq    out  1   interrupt request = irq_flag & CTRL.IM
// ---------------------------------------------------------------------------
module timer_irq_source
   import timer_irq_source_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  addr,
   input  logic        we,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irq
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t           state;
   logic             ctrl_en;
   logic [1:0]       ctrl_mode;
   logic             ctrl_im;
   logic [CNT_W-1:0] preset;
   logic [CNT_W-1:0] count;
   logic             irq_flag;

   logic ctrl_wr;
   logic preset_wr;

   assign ctrl_wr   = we && (addr == OFF_CTRL);
   assign preset_wr = we && (addr == OFF_PRESET);

   // Both inputs are flops, so the request is glitch-free and synchronous.
   assign irq = irq_flag & ctrl_im;

   // NOTE: non-blocking assignments throughout; where two assignments to the
   // same register fall on one edge, the later one in this block wins. That
   // ordering is deliberate below: the FSM's flag set follows the software
   // acknowledge so a new expiry is never lost.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         ctrl_en   <= 1'b0;
         ctrl_mode <= MODE_ONESHOT;
         ctrl_im   <= 1'b0;
         preset    <= '0;
         count     <= '0;
         irq_flag  <= 1'b0;
      end else begin
         // Any CTRL write acknowledges, even if the value is unchanged.
         if (ctrl_wr) begin
            ctrl_en   <= wdata[CTRL_EN_BIT];
            ctrl_mode <= wdata[CTRL_MODE_HI:CTRL_MODE_LO];
            ctrl_im   <= wdata[CTRL_IM_BIT];
            irq_flag  <= 1'b0;
         end

         // PRESET is only consumed in LOAD, so a write mid-count waits for the next reload.
         if (preset_wr) begin
            preset <= wdata[CNT_W-1:0];
         end

         case (state)
            ST_IDLE: begin
               if (ctrl_en) begin
                  state <= ST_LOAD;
               end
            end

            ST_LOAD: begin
               count <= preset;
               state <= ST_CNT;
            end

            ST_CNT: begin
               if (!ctrl_en) begin
                  state <= ST_IDLE;              // COUNT holds; re-enable reloads
               end else if (count > CNT_ONE) begin
                  count <= count - CNT_ONE;
               end else begin
                  // count is 1 or 0 (PRESET of 0); both expire without wrapping
                  count    <= '0;
                  irq_flag <= 1'b1;
                  state    <= ST_INT;
               end
            end

            ST_INT: begin
               if (is_reload(ctrl_mode)) begin
                  irq_flag <= 1'b0;
                  state    <= ST_LOAD;
               end else begin
                  // A software CTRL write on this edge keeps its Enable value.
                  if (!ctrl_wr) begin
                     ctrl_en <= 1'b0;
                  end
                  state <= ST_IDLE;
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

   // NOTE: rdata gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      rdata = '0;
      case (addr)
         OFF_CTRL: begin
            rdata[CTRL_EN_BIT]               = ctrl_en;
            rdata[CTRL_MODE_HI:CTRL_MODE_LO] = ctrl_mode;
            rdata[CTRL_IM_BIT]               = ctrl_im;
         end
         OFF_PRESET: rdata[CNT_W-1:0] = preset;
         OFF_COUNT:  rdata[CNT_W-1:0] = count;
         OFF_RSVD:   rdata = '0;
      endcase
   end

endmodule

// File: tb/tb_timer_irq_source.sv
// ---------------------------------------------------------------------------
// tb_timer_irq_source
//   Self-checking bench for timer_irq_source. Directed scenarios check the
//   documented latencies with explicit expected values; a randomized phase
//   compares every register and irq against a rule-level reference model.
// ---------------------------------------------------------------------------
module tb_timer_irq_source;

   logic        clk;
   logic        reset;
   logic [1:0]  addr;
   logic        we;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        irq;

   int n_vec = 0;
   int n_mis = 0;

   timer_irq_source #(.CNT_W(32)) dut (
      .clk   (clk),
      .reset (reset),
      .addr  (addr),
      .we    (we),
      .wdata (wdata),
      .rdata (rdata),
      .irq   (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   localparam int PH_IDLE  = 0;   // waiting for Enable
   localparam int PH_LOAD  = 1;   // next edge copies PRESET into COUNT
   localparam int PH_COUNT = 2;   // counting down
   localparam int PH_FIRED = 3;   // the cycle right after expiry

   int          m_phase;
   bit          m_en;
   bit [1:0]    m_mode;
   bit          m_im;
   int unsigned m_preset;
   int unsigned m_count;
   bit          m_flag;

   task automatic model_reset();
      m_phase  = PH_IDLE;
      m_en     = 1'b0;
      m_mode   = 2'b00;
      m_im     = 1'b0;
      m_preset = 0;
      m_count  = 0;
      m_flag   = 1'b0;
   endtask

   // One clock edge of the timer, from the register-map rules.
   task automatic model_step(input bit r, input bit w, input bit [1:0] a, input bit [31:0] d);
      bit sw_ctrl;
      bit expire;
      bit auto_clear;
      bit hw_disable;
      int next_phase;
      if (r) begin
         model_reset();
         return;
      end
      sw_ctrl    = w && (a == 2'd0);
      expire     = 1'b0;
      auto_clear = 1'b0;
      hw_disable = 1'b0;
      next_phase = m_phase;
      if (m_phase == PH_IDLE) begin
         if (m_en) next_phase = PH_LOAD;
      end else if (m_phase == PH_LOAD) begin
         m_count    = m_preset;
         next_phase = PH_COUNT;
      end else if (m_phase == PH_COUNT) begin
         if (!m_en) next_phase = PH_IDLE;
         else if (m_count > 1) m_count = m_count - 1;
         else begin
            m_count    = 0;
            expire     = 1'b1;
            next_phase = PH_FIRED;
         end
      end else begin
         if (m_mode == 2'b01) begin
            auto_clear = 1'b1;
            next_phase = PH_LOAD;
         end else begin
            hw_disable = 1'b1;
            next_phase = PH_IDLE;
         end
      end
      // Flag: a new expiry beats any clear on the same edge.
      if (expire) m_flag = 1'b1;
      else if (sw_ctrl || auto_clear) m_flag = 1'b0;
      // Enable: a software write beats the automatic one-shot disable.
      if (sw_ctrl) begin
         m_en   = d[0];
         m_mode = d[2:1];
         m_im   = d[3];
      end else if (hw_disable) begin
         m_en = 1'b0;
      end
      if (w && (a == 2'd1)) m_preset = d;
      m_phase = next_phase;
   endtask

   function automatic logic [31:0] m_read(input bit [1:0] a);
      case (a)
         2'd0:    return {28'd0, m_im, m_mode, m_en};
         2'd1:    return m_preset;
         2'd2:    return m_count;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic m_irq();
      return m_flag & m_im;
   endfunction

   // ---------------- stimulus helpers ----------------
   // Drive one cycle's inputs, advance one edge, update the model, then release strobes.
   task automatic apply(input bit r, input bit w, input bit [1:0] a, input bit [31:0] d);
      reset = r;
      we    = w;
      addr  = a;
      wdata = d;
      @(posedge clk);
      model_step(r, w, a, d);
      #1;
      reset = 1'b0;
      we    = 1'b0;
      wdata = 32'd0;
   endtask

   task automatic idle();
      apply(1'b0, 1'b0, 2'd0, 32'd0);
   endtask

   task automatic read_reg(input bit [1:0] a, output logic [31:0] v);
      addr = a;
      #1;
      v = rdata;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      logic [31:0] v;
      apply(1'b1, 1'b0, 2'd0, 32'd0);
      apply(1'b1, 1'b0, 2'd0, 32'd0);
      for (int a = 0; a < 4; a++) begin
         read_reg(2'(a), v);
         n_vec++;
         if (v !== 32'd0) begin
            n_mis++;
            $display("FAIL reset_rdata[%0d]: got %08h expected %08h", a, v, 32'd0);
         end
      end
      n_vec++;
      if (irq !== 1'b0) begin
         n_mis++;
         $display("FAIL reset_irq: got %b expected 0", irq);
      end
   endtask

   task automatic test_oneshot();
      logic [31:0] v;
      logic [31:0] exp_cnt;
      apply(1'b1, 1'b0, 2'd0, 32'd0);
      apply(1'b0, 1'b1, 2'd1, 32'd5);
      apply(1'b0, 1'b1, 2'd0, 32'h9);       // edge E
      for (int k = 1; k <= 9; k++) begin
         idle();                            // edge E+k
         if (k >= 2) begin
            exp_cnt = (k < 7) ? 32'(7 - k) : 32'd0;
            read_reg(2'd2, v);
            n_vec++;
            if (v !== exp_cnt) begin
               n_mis++;
               $display("FAIL oneshot_count k=%0d: got %0d expected %0d", k, v, exp_cnt);
            end
         end
         n_vec++;
         if (irq !== (k >= 7)) begin
            n_mis++;
            $display("FAIL oneshot_irq k=%0d: got %b expected %b", k, irq, (k >= 7));
         end
      end
      read_reg(2'd0, v);
      n_vec++;
      if (v !== 32'h8) begin
         n_mis++;
         $display("FAIL oneshot_ctrl_after: got %08h expected %08h", v, 32'h8);
      end
      apply(1'b0, 1'b1, 2'd0, 32'h8);       // acknowledge
      n_vec++;
      if (irq !== 1'b0) begin
         n_mis++;
         $display("FAIL oneshot_ack: got %b expected 0", irq);
      end
   endtask

   task automatic test_autoreload();
      int pulses;
      apply(1'b1, 1'b0, 2'd0, 32'd0);
      apply(1'b0, 1'b1, 2'd1, 32'd3);
      apply(1'b0, 1'b1, 2'd0, 32'hB);       // edge E
      pulses = 0;
      for (int k = 1; k <= 20; k++) begin
         idle();
         if (irq === 1'b1) pulses++;
         n_vec++;
         if (irq !== (k % 5 == 0)) begin
            n_mis++;
            $display("FAIL reload_irq k=%0d: got %b expected %b", k, irq, (k % 5 == 0));
         end
      end
      n_vec++;
      if (pulses !== 4) begin
         n_mis++;
         $display("FAIL reload_pulse_count: got %0d expected 4", pulses);
      end
      apply(1'b0, 1'b1, 2'd0, 32'h0);
      for (int k = 0; k < 4; k++) idle();
   endtask

   task automatic test_zero_preset();
      apply(1'b1, 1'b0, 2'd0, 32'd0);
      apply(1'b0, 1'b1, 2'd1, 32'd0);
      apply(1'b0, 1'b1, 2'd0, 32'h9);
      for (int k = 1; k <= 5; k++) begin
         idle();
         n_vec++;
         if (irq !== (k >= 3)) begin
            n_mis++;
            $display("FAIL zero_preset_irq k=%0d: got %b expected %b", k, irq, (k >= 3));
         end
      end
   endtask

   task automatic test_mid_stop();
      logic [31:0] v;
      apply(1'b1, 1'b0, 2'd0, 32'd0);
      apply(1'b0, 1'b1, 2'd1, 32'd10);
      apply(1'b0, 1'b1, 2'd0, 32'h9);       // edge E
      for (int k = 1; k <= 5; k++) idle();
      apply(1'b0, 1'b1, 2'd0, 32'h8);       // edge E+6, COUNT becomes 6 here
      for (int k = 0; k < 4; k++) begin
         idle();
         read_reg(2'd2, v);
         n_vec++;
         if (v !== 32'd6) begin
            n_mis++;
            $display("FAIL midstop_count c=%0d: got %0d expected 6", k, v);
         end
         n_vec++;
         if (irq !== 1'b0) begin
            n_mis++;
            $display("FAIL midstop_irq c=%0d: got %b expected 0", k, irq);
         end
      end
      apply(1'b0, 1'b1, 2'd0, 32'h9);       // re-enable
      idle();                               // LOAD edge pending
      read_reg(2'd2, v);
      n_vec++;
      if (v !== 32'd6) begin
         n_mis++;
         $display("FAIL midstop_before_reload: got %0d expected 6", v);
      end
      idle();
      read_reg(2'd2, v);
      n_vec++;
      if (v !== 32'd10) begin
         n_mis++;
         $display("FAIL midstop_reload: got %0d expected 10", v);
      end
   endtask

   task automatic test_mask_and_races();
      logic [31:0] v;
      // Expiry with IM=0 sets the flag invisibly; CTRL write on the expiry edge still sees it.
      apply(1'b1, 1'b0, 2'd0, 32'd0);
      apply(1'b0, 1'b1, 2'd1, 32'd2);
      apply(1'b0, 1'b1, 2'd0, 32'h1);
      for (int k = 1; k <= 3; k++) begin
         idle();
         n_vec++;
         if (irq !== 1'b0) begin
            n_mis++;
            $display("FAIL mask_pre_irq k=%0d: got %b expected 0", k, irq);
         end
      end
      apply(1'b0, 1'b1, 2'd0, 32'h8);       // coincides with expiry edge
      n_vec++;
      if (irq !== 1'b1) begin
         n_mis++;
         $display("FAIL set_wins_over_ack: got %b expected 1", irq);
      end
      idle();
      n_vec++;
      if (irq !== 1'b1) begin
         n_mis++;
         $display("FAIL set_wins_hold: got %b expected 1", irq);
      end

      // Masked expiry followed by a later CTRL write: the write acknowledges it.
      apply(1'b1, 1'b0, 2'd0, 32'd0);
      apply(1'b0, 1'b1, 2'd1, 32'd2);
      apply(1'b0, 1'b1, 2'd0, 32'h1);
      for (int k = 1; k <= 6; k++) idle();
      apply(1'b0, 1'b1, 2'd0, 32'h8);
      for (int k = 0; k < 3; k++) begin
         n_vec++;
         if (irq !== 1'b0) begin
            n_mis++;
            $display("FAIL mask_ack_irq c=%0d: got %b expected 0", k, irq);
         end
         idle();
      end

      // CTRL write on the INT edge keeps Enable=1 and the timer runs again.
      apply(1'b1, 1'b0, 2'd0, 32'd0);
      apply(1'b0, 1'b1, 2'd1, 32'd2);
      apply(1'b0, 1'b1, 2'd0, 32'h9);       // edge E
      for (int k = 1; k <= 4; k++) idle();
      n_vec++;
      if (irq !== 1'b1) begin
         n_mis++;
         $display("FAIL race_first_expiry: got %b expected 1", irq);
      end
      apply(1'b0, 1'b1, 2'd0, 32'h9);       // edge E+5, in INT
      read_reg(2'd0, v);
      n_vec++;
      if (v !== 32'h9) begin
         n_mis++;
         $display("FAIL sw_write_wins_in_int: got %08h expected %08h", v, 32'h9);
      end
      n_vec++;
      if (irq !== 1'b0) begin
         n_mis++;
         $display("FAIL race_ack_irq: got %b expected 0", irq);
      end
      for (int k = 6; k <= 9; k++) idle();
      n_vec++;
      if (irq !== 1'b1) begin
         n_mis++;
         $display("FAIL race_second_expiry: got %b expected 1", irq);
      end

      // Auto-reload with IM enabled later: pulses appear only once IM=1.
      apply(1'b1, 1'b0, 2'd0, 32'd0);
      apply(1'b0, 1'b1, 2'd1, 32'd2);
      apply(1'b0, 1'b1, 2'd0, 32'h3);       // edge E
      for (int k = 1; k <= 10; k++) begin
         idle();
         n_vec++;
         if (irq !== 1'b0) begin
            n_mis++;
            $display("FAIL masked_reload_irq k=%0d: got %b expected 0", k, irq);
         end
      end
      apply(1'b0, 1'b1, 2'd0, 32'hB);       // edge E+11
      for (int k = 12; k <= 20; k++) begin
         idle();
         n_vec++;
         if (irq !== (k % 4 == 0)) begin
            n_mis++;
            $display("FAIL unmasked_reload_irq k=%0d: got %b expected %b", k, irq, (k % 4 == 0));
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] v;
      bit          r;
      bit          w;
      bit [1:0]    a;
      bit [31:0]   d;
      apply(1'b1, 1'b0, 2'd0, 32'd0);
      for (int n = 0; n < 1500; n++) begin
         r = ($urandom_range(0, 299) == 0);
         w = ($urandom_range(0, 3) == 0);
         a = 2'($urandom_range(0, 3));
         if (a == 2'd1) d = $urandom_range(0, 7);
         else d = $urandom;
         apply(r, w, a, d);
         for (int i = 0; i < 4; i++) begin
            read_reg(2'(i), v);
            n_vec++;
            if (v !== m_read(2'(i))) begin
               n_mis++;
               $display("FAIL random_rdata[%0d] n=%0d: got %08h expected %08h", i, n, v, m_read(2'(i)));
            end
         end
         n_vec++;
         if (irq !== m_irq()) begin
            n_mis++;
            $display("FAIL random_irq n=%0d: got %b expected %b", n, irq, m_irq());
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      we    = 1'b0;
      addr  = 2'd0;
      wdata = 32'd0;
      model_reset();
      test_reset();
      test_oneshot();
      test_autoreload();
      test_zero_preset();
      test_mid_stop();
      test_mask_and_races();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
